// File: rtl/loader_pkg.sv
// Shared types for the boot-time instruction loader: FSM state encoding and word geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/insn_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k lands in bits [8k+7:8k]; the word is
// presented combinationally alongside the accept of its final byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int LO_W  = 8 * (BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx;
  logic [LO_W-1:0]  lo;

  assign word_valid = in_valid && (idx == IDX_W'(BYTES_PER_WORD - 1));
  // The top byte never needs storing; it is spliced straight in on its accept cycle.
  assign word       = {in_byte, lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      lo  <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        idx <= '0;
      end else begin
        idx           <= idx + IDX_W'(1);
        lo[8*idx +: 8] <= in_byte;
      end
    end
  end

endmodule

// File: rtl/insn_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory and holds
// the core in reset until the image is fully written and verified.
module insn_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t          state;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [7:0]      csum;
  logic [ADDR_W:0] widx;
  logic            acc;
  logic            pk_valid;
  logic [31:0]     pk_word;
  logic [15:0]     n_hdr;
  logic [15:0]     widx_nx;

  assign rx_ready = !reset && (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});
  assign acc      = rx_valid && rx_ready;
  assign n_hdr    = {rx_data, len_lo};
  assign widx_nx  = 16'(widx) + 16'd1;
  // The word index advances on the same edge that raises mem_we, so it doubles as the count.
  assign words_loaded = widx;

  byte_packer u_pack (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (acc && (state == S_DATA)),
    .in_byte    (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LEN_LO;
      len_lo     <= '0;
      len        <= '0;
      csum       <= '0;
      widx       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (acc && state != S_CSUM) csum <= csum ^ rx_data;
      case (state)
        S_LEN_LO: if (acc) begin
          len_lo <= rx_data;
          busy   <= 1'b1;
          state  <= S_LEN_HI;
        end
        S_LEN_HI: if (acc) begin
          len <= n_hdr;
          if (n_hdr == 16'd0) begin
            state <= S_CSUM;
          end else if (n_hdr > 16'(MAX_WORDS)) begin
            state <= S_ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (pk_valid) begin
          mem_we    <= 1'b1;
          mem_addr  <= widx[ADDR_W-1:0];
          mem_wdata <= pk_word;
          widx      <= widx + 1'b1;
          if (widx_nx == len) state <= S_CSUM;
        end
        // csum here already folds in byte 3 of the last word, accepted the cycle before.
        S_CSUM: if (acc) begin
          busy <= 1'b0;
          if (rx_data == csum) begin
            state      <= S_RUN;
            done       <= 1'b1;
            core_reset <= 1'b0;
          end else begin
            state <= S_ERR;
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: table of streams plus hand-written reset and
// full-size sequences; memory writes are checked against a scoreboard queue.
module tb_insn_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  typedef struct {
    int src;
    bit stall;
    bit exp_done;
    bit exp_err;
    int exp_words;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, mem_we, core_reset, busy, done, error;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int nwr = 0;
  bit prev_we = 1'b0;
  wr_t sb[$];
  logic [31:0] tb_mem [1024];
  logic [31:0] exp_nom [3];
  vec_t tbl [6];

  insn_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we must match the head of the scoreboard, address, data and cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      nwr++;
      tb_mem[mem_addr] = mem_wdata;
      chk("we_not_back_to_back", {63'd0, prev_we}, 64'd0);
      if (sb.size() == 0) begin
        chk("stray_write_addr", {54'd0, mem_addr}, 64'hFFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {54'd0, mem_addr}, {54'd0, e.addr});
        chk("wr_data", {32'd0, mem_wdata}, {32'd0, e.data});
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_we = (mem_we === 1'b1);
  end

  task automatic build(input int src, output bq_t s);
    case (src)
      0: s = '{8'h03, 8'h00, 8'h93, 8'h80, 8'hC0, 8'h00, 8'h13, 8'h81, 8'h20, 8'h01,
               8'hB3, 8'hE1, 8'h20, 8'h00, 8'h11};
      1: s = '{8'h03, 8'h00, 8'h93, 8'h80, 8'hC0, 8'h00, 8'h13, 8'h81, 8'h20, 8'h01,
               8'hB3, 8'hE1, 8'h20, 8'h00, 8'h12};
      2: s = '{8'h01, 8'h08};
      3: s = '{8'h00, 8'h00, 8'h00};
      default: s = '{8'h00, 8'h00, 8'h01};
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives a stream; the model decodes the header itself and predicts each write.
  task automatic run_stream(input bq_t s, input bit stall, input bit exp_done,
                            input bit exp_err, input int exp_words);
    int pos = 0;
    int n = 0;
    logic [31:0] w = '0;
    bit stop = 1'b0;
    for (int i = 0; i < s.size() && !stop; i++) begin
      bit v;
      int budget = 0;
      do begin
        @(negedge clk);
        v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (budget > 16) v = 1'b1;
        budget++;
        rx_valid = v;
        rx_data = v ? s[i] : 8'($urandom);
      end while (!v);
      if (rx_ready !== 1'b1) begin
        chk("rx_ready_mid_stream", {63'd0, rx_ready}, 64'd1);
        stop = 1'b1;
      end else begin
        if (pos == 0) n[7:0] = s[i];
        else if (pos == 1) n[15:8] = s[i];
        else if (n <= 1024 && pos < 2 + 4 * n) begin
          int k = (pos - 2) % 4;
          w[8*k +: 8] = s[i];
          if (k == 3) begin
            wr_t e;
            e.addr = 10'((pos - 2) / 4);
            e.data = w;
            e.cyc = cyc + 1;
            sb.push_back(e);
          end
        end
        pos++;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("done_after_last", {63'd0, done}, {63'd0, exp_done});
    chk("error_after_last", {63'd0, error}, {63'd0, exp_err});
    chk("core_reset_after_last", {63'd0, core_reset}, {63'd0, !exp_done});
    repeat (3) @(negedge clk);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("rx_ready_terminal", {63'd0, rx_ready}, 64'd0);
    chk("words_loaded", {53'd0, words_loaded}, 64'(exp_words));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t s;
    exp_nom = '{32'h00C08093, 32'h01208113, 32'h0020E1B3};
    tbl[0] = '{0, 1'b0, 1'b1, 1'b0, 3};
    tbl[1] = '{0, 1'b1, 1'b1, 1'b0, 3};
    tbl[2] = '{1, 1'b0, 1'b0, 1'b1, 3};
    tbl[3] = '{2, 1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{3, 1'b1, 1'b1, 1'b0, 0};
    tbl[5] = '{4, 1'b0, 1'b0, 1'b1, 0};

    @(negedge clk);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    @(negedge clk);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
    chk("rst_flags", {61'd0, busy, done, error}, 64'd0);
    chk("rst_words", {53'd0, words_loaded}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", {63'd0, rx_ready}, 64'd1);

    foreach (tbl[t]) begin
      do_reset();
      for (int a = 0; a < 3; a++) tb_mem[a] = 32'hDEAD_BEEF;
      nwr = 0;
      build(tbl[t].src, s);
      run_stream(s, tbl[t].stall, tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_words);
      chk("write_count", 64'(nwr), 64'(tbl[t].exp_words));
      if (tbl[t].src <= 1)
        for (int a = 0; a < 3; a++) chk("nominal_mem", {32'd0, tb_mem[a]}, {32'd0, exp_nom[a]});
    end

    // Reset after the second data byte: partial word must vanish.
    do_reset();
    nwr = 0;
    build(0, s);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = s[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1 chk("midrst_rx_ready", {63'd0, rx_ready}, 64'd0);
    @(negedge clk);
    chk("midrst_flags", {60'd0, mem_we, busy, done, error}, 64'd0);
    chk("midrst_core_reset", {63'd0, core_reset}, 64'd1);
    chk("midrst_words", {53'd0, words_loaded}, 64'd0);
    reset = 1'b0;
    for (int a = 0; a < 3; a++) tb_mem[a] = 32'hDEAD_BEEF;
    run_stream(s, 1'b0, 1'b1, 1'b0, 3);
    chk("midrst_write_count", 64'(nwr), 64'd3);
    for (int a = 0; a < 3; a++) chk("midrst_mem", {32'd0, tb_mem[a]}, {32'd0, exp_nom[a]});

    // Full-size image: N == 1024 reaches address 1023 without wrapping.
    do_reset();
    nwr = 0;
    begin
      logic [7:0] x;
      logic [31:0] last;
      s = '{8'h00, 8'h04};
      x = 8'h04;
      for (int i = 0; i < 4096; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        s.push_back(b);
        x ^= b;
        if (i >= 4092) last[8*(i-4092) +: 8] = b;
      end
      s.push_back(x);
      run_stream(s, 1'b0, 1'b1, 1'b0, 1024);
      chk("max_write_count", 64'(nwr), 64'd1024);
      chk("max_last_word", {32'd0, tb_mem[1023]}, {32'd0, last});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
